// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl
// Run/pause/lap/clear sequencer for a 4-digit packed-BCD counter chain.
// It turns debounced start/stop and lap/reset button levels into one-cycle
// enable and clear strobes for the counter, freezes a lap value for the
// display, and parks the chain at 9999 instead of letting it wrap.
`timescale 1ns/1ps

module stopwatch_ctrl #(
    parameter int unsigned TICK_DIV = 1000000   // clk cycles per count increment, 2..2^24
) (
    input  logic        i_clk,
    input  logic        i_grst,        // synchronous, active-high; shared with the counter chain
    input  logic        i_btn_ss,      // start/stop level, debounced
    input  logic        i_btn_lr,      // lap/reset level, debounced
    input  logic [15:0] i_cnt_val,     // counter value {d3,d2,d1,d0}
    input  logic        i_cnt_tc,      // counter sits at 9999
    output logic        o_cnt_en,      // one-cycle increment strobe
    output logic        o_cnt_clr,     // one-cycle clear strobe
    output logic [15:0] o_disp,        // value for the display multiplexer
    output logic        o_running,     // RUN or LAP
    output logic        o_lap_act,     // LAP: display frozen
    output logic        o_ovf          // chain stopped at 9999
);

    // Prescaler only ever holds 0..TICK_DIV-1.
    localparam int unsigned   PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [15:0]   DISP_FULL = 16'h9999;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_PAUSE = 3'd2,
        S_LAP   = 3'd3,
        S_OVF   = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_next_state;

    logic          r_ss_q;
    logic          r_ss_d;
    logic          r_lr_q;
    logic          r_lr_d;
    logic          w_ss_press;
    logic          w_lr_press;

    logic [PW-1:0] r_presc;
    logic          w_live;
    logic          w_tick;

    logic          w_clr_req;
    logic          w_lap_capture;
    logic [15:0]   r_lap;

    logic          w_running;
    logic          w_lap_act;
    logic          w_ovf;
    logic [15:0]   w_disp;

    logic          r_cnt_en;
    logic          r_cnt_clr;
    logic [15:0]   r_disp;
    logic          r_running;
    logic          r_lap_act;
    logic          r_ovf;

    // Sample both button levels once and keep the previous sample for edge detection.
    // NOTE: clocked state is written with <= so every flop sees the pre-edge values of its neighbours.
    always_ff @(posedge i_clk) begin
        if (i_grst) begin
            r_ss_q <= 1'b0;
            r_ss_d <= 1'b0;
            r_lr_q <= 1'b0;
            r_lr_d <= 1'b0;
        end else begin
            r_ss_q <= i_btn_ss;
            r_ss_d <= r_ss_q;
            r_lr_q <= i_btn_lr;
            r_lr_d <= r_lr_q;
        end
    end

    // A press is the rising edge of the sampled level; start/stop beats lap/reset.
    assign w_ss_press = r_ss_q & ~r_ss_d;
    assign w_lr_press = r_lr_q & ~r_lr_d & ~w_ss_press;

    // The time base advances only while the stopwatch is counting.
    assign w_live = (r_state == S_RUN) || (r_state == S_LAP);
    assign w_tick = w_live && (r_presc == TICK_LAST);

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_grst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decision plus the clear and lap-capture side effects of each transition.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_next_state  = r_state;
        w_clr_req     = 1'b0;
        w_lap_capture = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_ss_press) begin
                    w_next_state = S_RUN;
                end else if (w_lr_press) begin
                    w_clr_req = 1'b1;
                end
            end
            S_RUN: begin
                if (w_ss_press) begin
                    w_next_state = S_PAUSE;
                end else if (w_lr_press) begin
                    w_next_state  = S_LAP;
                    w_lap_capture = 1'b1;
                end else if (w_tick && i_cnt_tc) begin
                    w_next_state = S_OVF;
                end
            end
            S_LAP: begin
                if (w_ss_press) begin
                    w_next_state = S_PAUSE;
                end else if (w_lr_press) begin
                    w_next_state = S_RUN;
                end else if (w_tick && i_cnt_tc) begin
                    w_next_state = S_OVF;
                end
            end
            S_PAUSE: begin
                if (w_ss_press) begin
                    w_next_state = S_RUN;
                end else if (w_lr_press) begin
                    w_next_state = S_IDLE;
                    w_clr_req    = 1'b1;
                end
            end
            S_OVF: begin
                // Start/stop is ignored here; only lap/reset leaves the overflow hold.
                if (w_lr_press) begin
                    w_next_state = S_IDLE;
                    w_clr_req    = 1'b1;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Prescaler: wraps every TICK_DIV live cycles, holds through PAUSE, restarts on IDLE/OVF entry.
    always_ff @(posedge i_clk) begin
        if (i_grst) begin
            r_presc <= '0;
        end else if ((w_next_state == S_IDLE) || (w_next_state == S_OVF)) begin
            r_presc <= '0;
        end else if (w_live) begin
            r_presc <= w_tick ? '0 : r_presc + PW'(1);
        end
    end

    // Lap register: freezes the counter value seen in the cycle the lap press is detected.
    always_ff @(posedge i_clk) begin
        if (i_grst) begin
            r_lap <= '0;
        end else if (w_lap_capture) begin
            r_lap <= i_cnt_val;
        end
    end

    // Output decode from the current state, ahead of the output registers.
    always_comb begin
        w_running = w_live;
        w_lap_act = (r_state == S_LAP);
        w_ovf     = (r_state == S_OVF);
        if (r_state == S_LAP) begin
            w_disp = r_lap;
        end else if (r_state == S_OVF) begin
            w_disp = DISP_FULL;
        end else begin
            w_disp = i_cnt_val;
        end
    end

    // Output registers; the enable is withheld at 9999 so the chain never wraps.
    always_ff @(posedge i_clk) begin
        if (i_grst) begin
            r_cnt_en  <= 1'b0;
            r_cnt_clr <= 1'b0;
            r_disp    <= '0;
            r_running <= 1'b0;
            r_lap_act <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_cnt_en  <= w_tick & ~i_cnt_tc;
            r_cnt_clr <= w_clr_req;
            r_disp    <= w_disp;
            r_running <= w_running;
            r_lap_act <= w_lap_act;
            r_ovf     <= w_ovf;
        end
    end

    assign o_cnt_en  = r_cnt_en;
    assign o_cnt_clr = r_cnt_clr;
    assign o_disp    = r_disp;
    assign o_running = r_running;
    assign o_lap_act = r_lap_act;
    assign o_ovf     = r_ovf;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl
// Drives stopwatch_ctrl against a behavioural BCD counter, with a reference
// model that predicts every output cycle and a monitor that compares them.
`timescale 1ns/1ps

module tb_stopwatch_ctrl;

    localparam int DIV = 4;

    typedef enum {M_IDLE, M_RUN, M_PAUSE, M_LAP, M_OVF} mode_t;

    typedef struct packed {
        logic        en;
        logic        clr;
        logic [15:0] disp;
        logic        run;
        logic        lap;
        logic        ovf;
    } out_t;

    logic        clk;
    logic        grst;
    logic        btn_ss;
    logic        btn_lr;
    logic [15:0] cnt_val;
    logic        cnt_tc;
    logic        cnt_en;
    logic        cnt_clr;
    logic [15:0] disp;
    logic        running;
    logic        lap_act;
    logic        ovf;

    // Counter preload, used to reach the interesting values quickly.
    logic        ld;
    logic [15:0] ld_val;

    int n_checks = 0;
    int n_fail   = 0;

    out_t sb_q[$];

    stopwatch_ctrl #(.TICK_DIV(DIV)) dut (
        .i_clk     (clk),
        .i_grst    (grst),
        .i_btn_ss  (btn_ss),
        .i_btn_lr  (btn_lr),
        .i_cnt_val (cnt_val),
        .i_cnt_tc  (cnt_tc),
        .o_cnt_en  (cnt_en),
        .o_cnt_clr (cnt_clr),
        .o_disp    (disp),
        .o_running (running),
        .o_lap_act (lap_act),
        .o_ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic int from_bcd(input logic [15:0] b);
        return int'(b[15:12]) * 1000 + int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    // Behavioural 4-digit BCD counter chain (wraps like real hardware if enabled at 9999).
    assign cnt_tc = (cnt_val == 16'h9999);
    always @(posedge clk) begin
        if (grst || cnt_clr) begin
            cnt_val <= 16'h0000;
        end else if (ld) begin
            cnt_val <= ld_val;
        end else if (cnt_en) begin
            cnt_val <= to_bcd((from_bcd(cnt_val) + 1) % 10000);
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input bit ss, input bit lr);
        if (ss) btn_ss = 1'b1;
        if (lr) btn_lr = 1'b1;
        cyc(2);
        btn_ss = 1'b0;
        btn_lr = 1'b0;
    endtask

    task automatic wait_cnt(input logic [15:0] v, input int budget, input string nm);
        int k;
        k = 0;
        while (cnt_val !== v && k < budget) begin
            cyc(1);
            k++;
        end
        check(nm, 32'(cnt_val === v), 32'd1);
    endtask

    // Reference model: the stopwatch modes, a count of live cycles since the last
    // increment, and the counter value as a plain integer. Each edge predicts the
    // outputs visible for the following cycle.
    bit          m_on = 1'b0;
    mode_t       m_mode;
    int          m_phase;
    int          m_cnt;
    logic [15:0] m_lap;
    bit          m_ss1, m_ss2, m_lr1, m_lr2;
    bit          m_en_prev, m_clr_prev;

    initial begin : model
        out_t  e;
        mode_t nxt;
        bit    ss_p, lr_p, live, tick, tc, clr;
        forever begin
            @(posedge clk);
            if (grst) begin
                m_on       = 1'b1;
                m_mode     = M_IDLE;
                m_phase    = 0;
                m_cnt      = 0;
                m_lap      = 16'h0000;
                m_ss1      = 1'b0;
                m_ss2      = 1'b0;
                m_lr1      = 1'b0;
                m_lr2      = 1'b0;
                m_en_prev  = 1'b0;
                m_clr_prev = 1'b0;
                e          = '0;
                sb_q.push_back(e);
            end else if (m_on) begin
                ss_p = m_ss1 && !m_ss2;
                lr_p = m_lr1 && !m_lr2 && !ss_p;
                live = (m_mode == M_RUN) || (m_mode == M_LAP);
                tick = live && (m_phase == DIV - 1);
                tc   = (m_cnt == 9999);

                e.en   = tick && !tc;
                e.run  = live;
                e.lap  = (m_mode == M_LAP);
                e.ovf  = (m_mode == M_OVF);
                e.disp = (m_mode == M_LAP) ? m_lap :
                         (m_mode == M_OVF) ? 16'h9999 : to_bcd(m_cnt);

                nxt = m_mode;
                clr = 1'b0;
                case (m_mode)
                    M_IDLE: begin
                        if (ss_p) nxt = M_RUN;
                        else if (lr_p) clr = 1'b1;
                    end
                    M_RUN, M_LAP: begin
                        if (ss_p) begin
                            nxt = M_PAUSE;
                        end else if (lr_p) begin
                            if (m_mode == M_RUN) begin
                                nxt   = M_LAP;
                                m_lap = to_bcd(m_cnt);
                            end else begin
                                nxt = M_RUN;
                            end
                        end else if (tick && tc) begin
                            nxt = M_OVF;
                        end
                    end
                    M_PAUSE: begin
                        if (ss_p) nxt = M_RUN;
                        else if (lr_p) begin nxt = M_IDLE; clr = 1'b1; end
                    end
                    default: begin
                        if (lr_p) begin nxt = M_IDLE; clr = 1'b1; end
                    end
                endcase
                e.clr = clr;

                if (nxt == M_IDLE || nxt == M_OVF) m_phase = 0;
                else if (live) m_phase = tick ? 0 : m_phase + 1;
                m_mode = nxt;

                if (m_clr_prev) m_cnt = 0;
                else if (ld) m_cnt = from_bcd(ld_val);
                else if (m_en_prev) m_cnt = (m_cnt + 1) % 10000;
                m_en_prev  = e.en;
                m_clr_prev = e.clr;

                m_ss2 = m_ss1;
                m_ss1 = btn_ss;
                m_lr2 = m_lr1;
                m_lr1 = btn_lr;
                sb_q.push_back(e);
            end
        end
    end

    // Monitor: every cycle the DUT presents a full output set; compare it with the prediction.
    initial begin : monitor
        out_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("sb_cnt_en",  32'(cnt_en),  32'(e.en));
                check("sb_cnt_clr", 32'(cnt_clr), 32'(e.clr));
                check("sb_disp",    32'(disp),    32'(e.disp));
                check("sb_running", 32'(running), 32'(e.run));
                check("sb_lap_act", 32'(lap_act), 32'(e.lap));
                check("sb_ovf",     32'(ovf),     32'(e.ovf));
            end
        end
    end

    initial begin : stim
        logic [15:0] v;
        int k;
        btn_ss = 1'b0;
        btn_lr = 1'b0;
        grst   = 1'b1;
        ld     = 1'b0;
        ld_val = 16'h0000;
        cyc(3);
        check("rst_cnt_en",  32'(cnt_en),  32'd0);
        check("rst_cnt_clr", 32'(cnt_clr), 32'd0);
        check("rst_disp",    32'(disp),    32'd0);
        check("rst_running", 32'(running), 32'd0);
        check("rst_lap_act", 32'(lap_act), 32'd0);
        check("rst_ovf",     32'(ovf),     32'd0);
        grst = 1'b0;

        // Start: three increments after twelve-odd cycles of RUN.
        press(1'b1, 1'b0);
        cyc(14);
        check("run_count_0003", 32'(cnt_val), 32'h0003);
        check("run_running",    32'(running), 32'd1);

        // Pause at 0005, hold, then resume from the residual phase.
        wait_cnt(16'h0005, 40, "reach_0005");
        press(1'b1, 1'b0);
        cyc(40);
        check("pause_holds_0005", 32'(cnt_val), 32'h0005);
        check("pause_running",    32'(running), 32'd0);
        press(1'b1, 1'b0);

        // Lap at 0012: display freezes while the counter moves on.
        wait_cnt(16'h0012, 80, "reach_0012");
        press(1'b0, 1'b1);
        wait_cnt(16'h0020, 80, "reach_0020");
        check("lap_disp_frozen", 32'(disp),    32'h0012);
        check("lap_active",      32'(lap_act), 32'd1);
        press(1'b0, 1'b1);
        cyc(2);
        check("lap_released", 32'(lap_act), 32'd0);
        check("lap_running",  32'(running), 32'd1);

        // Simultaneous presses: start/stop wins, no clear.
        press(1'b1, 1'b1);
        cyc(3);
        v = cnt_val;
        cyc(10);
        check("simul_count_held", 32'(cnt_val), 32'(v));
        check("simul_no_clear",   32'(v != 16'h0000), 32'd1);
        check("simul_paused",     32'(running), 32'd0);
        check("simul_no_lap",     32'(lap_act), 32'd0);

        // Clear from PAUSE.
        press(1'b0, 1'b1);
        cyc(4);
        check("clr_count", 32'(cnt_val), 32'h0000);
        check("clr_disp",  32'(disp),    32'h0000);

        // Overflow: run from 9997 into the 9999 hold.
        ld_val = 16'h9997;
        ld     = 1'b1;
        cyc(1);
        ld     = 1'b0;
        check("preload_9997", 32'(cnt_val), 32'h9997);
        press(1'b1, 1'b0);
        wait_cnt(16'h9998, 20, "reach_9998");
        wait_cnt(16'h9999, 10, "reach_9999");
        k = 0;
        while (ovf !== 1'b1 && k < 12) begin
            cyc(1);
            k++;
        end
        check("ovf_set", 32'(ovf), 32'd1);
        cyc(8);
        check("ovf_count_9999", 32'(cnt_val), 32'h9999);
        check("ovf_disp_9999",  32'(disp),    32'h9999);
        press(1'b1, 1'b0);
        cyc(4);
        check("ovf_ss_ignored", 32'(ovf), 32'd1);
        press(1'b0, 1'b1);
        cyc(6);
        check("ovf_cleared",   32'(ovf),     32'd0);
        check("ovf_clr_disp",  32'(disp),    32'h0000);
        check("ovf_clr_count", 32'(cnt_val), 32'h0000);

        // Mid-run reset at 0347.
        ld_val = 16'h0345;
        ld     = 1'b1;
        cyc(1);
        ld     = 1'b0;
        press(1'b1, 1'b0);
        wait_cnt(16'h0347, 40, "reach_0347");
        grst = 1'b1;
        cyc(1);
        check("mrst_count",   32'(cnt_val), 32'h0000);
        check("mrst_disp",    32'(disp),    32'h0000);
        check("mrst_running", 32'(running), 32'd0);
        check("mrst_cnt_en",  32'(cnt_en),  32'd0);
        grst = 1'b0;
        press(1'b1, 1'b0);
        cyc(20);

        // Randomized button activity, preloads near the top and occasional resets.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 5) == 0) btn_ss = ~btn_ss;
            if ($urandom_range(0, 5) == 0) btn_lr = ~btn_lr;
            grst   = ($urandom_range(0, 299) == 0);
            ld     = ($urandom_range(0, 99) == 0);
            ld_val = ($urandom_range(0, 1) == 1) ? to_bcd(9990 + int'($urandom_range(0, 9)))
                                                  : to_bcd(int'($urandom_range(0, 9999)));
            cyc(1);
        end
        grst   = 1'b0;
        ld     = 1'b0;
        btn_ss = 1'b0;
        btn_lr = 1'b0;
        cyc(5);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Run/pause/lap/clear controller for the 4-digit BCD counter chain (16-bit packed BCD count, terminal-count flag). It turns two debounced push-button levels into counter enable and clear strobes from an internal prescaler, freezes a lap value for the seven-segment driver, and stops the chain at 9999 instead of letting it wrap. It sits between the button debouncers and the counter, and feeds the display multiplexer.

## Interface
- TICK_DIV, 1000000: clk cycles per count increment; legal range is 2..2^24.
- clk  in  1  system clock; all logic rises on posedge.
- grst  in  1  synchronous, active-high reset; the counter chain shares it.
- btn_ss  in  1  start/stop button level, debounced.
- btn_lr  in  1  lap/reset button level, debounced.
- cnt_val  in  16  counter value {d3,d2,d1,d0}, BCD.
- cnt_tc  in  1  high while the counter is at 9999.
- cnt_en  out  1  one-cycle increment strobe to the counter's enable.
- cnt_clr  out  1  one-cycle clear strobe, ORed with grst at the counter.
- disp  out  16  BCD value for the display.
- running  out  1  high in RUN or LAP.
- lap_act  out  1  high in LAP; disp is frozen.
- ovf  out  1  high in OVF.

## Operation
- Edge detect: btn_ss and btn_lr are registered once. A press is a rising edge of the registered level, one cycle long. Held buttons do not repeat.
- If both presses occur in the same cycle, ss wins and lr is discarded.
- States:
  - IDLE: ss → RUN. lr → IDLE and pulses cnt_clr.
  - RUN: ss → PAUSE. lr → LAP, latching cnt_val into lap_reg. A tick with cnt_tc=1 → OVF.
  - LAP: ss → PAUSE and unfreezes disp. lr → RUN and unfreezes. A tick with cnt_tc=1 → OVF.
  - PAUSE: ss → RUN. lr → IDLE and pulses cnt_clr.
  - OVF: lr → IDLE and pulses cnt_clr. ss is ignored.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN or LAP, and holds its value in PAUSE.
  - Clears to 0 on entering IDLE or OVF.
  - A tick occurs when prescaler == TICK_DIV-1 in RUN or LAP.
- cnt_en: registered, set to (tick & ~cnt_tc). The counter is never enabled at 9999, so there is no wrap.
- disp: registered, set to lap_reg in LAP and to cnt_val otherwise. In OVF it shows 9999.
- Outputs running, lap_act and ovf are decoded from the state register; the decode is registered.
- Reset values: state=IDLE, prescaler=0, lap_reg=0, cnt_en=0, cnt_clr=0, disp=0, running=0, lap_act=0, ovf=0.
- grst mid-operation overrides every other input in that cycle.

## Timing
- Press to state change: button level high at edge N, registered at N, edge detected at N+1, state updated at N+1 edge. running/lap_act/ovf follow one edge later.
- Tick to count: the tick decision at edge T sets cnt_en high for cycle T..T+1, and the counter increments at edge T+1.
- A press arriving while cnt_en is already high does not cancel that increment.
- cnt_clr is high for exactly one cycle, registered with the state transition. The counter reads 0000 one edge later, and disp shows 0000 one edge after that.
- Lap latch: lap_reg captures the cnt_val present in the detect cycle, and disp shows it one edge later.
- Increment spacing is exactly TICK_DIV cycles while continuously running. A pause/resume keeps the residual prescaler phase.

## Test plan
- Reset and start (TICK_DIV=4): reset, then one ss press → running=1 and cnt_en pulses every 4 cycles. The bench counter reads 0003 after 12 cycles of RUN; allow ±1 cycle for latency.
- Pause and resume: RUN until 0005, ss, wait 40 cycles, ss → count stays 0005 during PAUSE. The first increment after resume lands after the residual prescaler cycles, and spacing is 4 after that.
- Lap: RUN at 0012, lr → disp holds 0012 while cnt_val advances to 0020. A second lr → disp tracks cnt_val next cycle and lap_act=0.
- Overflow: preload the counter to 9997 and run → 9998, then 9999, then ovf=1 and cnt_en stays 0. The count remains 9999, ss is ignored, and lr → cnt_clr pulse, IDLE, disp=0000.
- Simultaneous presses: ss and lr rise in the same cycle in RUN → PAUSE, lap_reg unchanged, no clear.
- Mid-run reset: assert grst for 1 cycle at count 0347 → all outputs reset to 0 on the next edge, state IDLE, the counter reads 0000, and no cnt_en pulse for TICK_DIV cycles after the next ss.
